// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Channel index width; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner pick: highest index (mode 0) or rotating from ptr+1 (mode 1).
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int IW   = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] elig,
  input  logic [IW-1:0]   ptr,
  input  logic            mode,
  output logic [N_CH-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic found;

  assign any = |elig;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (mode) begin
      // k = N_CH lands back on ptr itself, so the last grantee is searched last.
      for (int k = 1; k <= N_CH; k++) begin
        if (!found && elig[(int'(ptr) + k) % N_CH]) begin
          idx   = IW'((int'(ptr) + k) % N_CH);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (elig[i]) idx = IW'(i);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel SRAM-style port merger with one memory transaction in flight.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_CH      = 2,
  parameter  int AW        = 32,
  parameter  int DW        = 32,
  parameter  int PRIO_MODE = 0,
  localparam int SW        = DW / 8,
  localparam int IW        = idx_w(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    ch_req,
  input  logic [N_CH-1:0]    ch_we,
  input  logic [N_CH*AW-1:0] ch_addr,
  input  logic [N_CH*DW-1:0] ch_wdata,
  input  logic [N_CH*SW-1:0] ch_wstrb,
  output logic [N_CH*DW-1:0] ch_rdata,
  output logic [N_CH-1:0]    ch_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic [SW-1:0]      mem_wstrb,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [DW-1:0]      mem_rdata
);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("mem_port_arbiter: N_CH must be 1..8");
  end
  if (DW % 8 != 0) begin : g_bad_dw
    $error("mem_port_arbiter: DW must be a multiple of 8");
  end

  arb_state_t      state, state_nx;
  logic [N_CH-1:0] elig, pick_oh;
  logic [IW-1:0]   pick, cur, ptr;
  logic            any, grant_fire, rsp_fire;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_wstrb;

  // A channel completing this cycle still holds ch_req; keep it out of the pick.
  assign elig = ch_req & ~ch_ready;

  rr_arbiter #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .mode (PRIO_MODE == ARB_RR),
    .gnt  (pick_oh),
    .idx  (pick),
    .any  (any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick_oh[i]) begin
        sel_we    = sel_we | ch_we[i];
        sel_addr  = sel_addr | ch_addr[i*AW +: AW];
        sel_wdata = sel_wdata | ch_wdata[i*DW +: DW];
        sel_wstrb = sel_wstrb | ch_wstrb[i*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    grant_fire = 1'b0;
    rsp_fire   = 1'b0;
    unique case (state)
      IDLE: if (any) begin
        state_nx   = REQ;
        grant_fire = 1'b1;
      end
      REQ:  if (mem_gnt) state_nx = RESP;
      RESP: if (mem_rvalid) begin
        state_nx = IDLE;
        rsp_fire = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request registers hold the latched transaction until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      cur       <= '0;
      ptr       <= '0;
    end else if (grant_fire) begin
      mem_req   <= 1'b1;
      mem_we    <= sel_we;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
      mem_wstrb <= sel_we ? sel_wstrb : '0;
      cur       <= pick;
      ptr       <= pick;
    end else if (state == REQ && mem_gnt) begin
      mem_req   <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          hit;
    logic          rdy_r;
    logic [DW-1:0] rdata_r;

    assign hit = rsp_fire && (cur == IW'(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdy_r   <= 1'b0;
        rdata_r <= '0;
      end else begin
        rdy_r <= hit;
        if (hit && !mem_we) rdata_r <= mem_rdata;
      end
    end

    assign ch_ready[g]           = rdy_r;
    assign ch_rdata[g*DW +: DW]  = rdata_r;
  end

endmodule
